// File: rtl/lcd12864_pkg.sv
// rtl/lcd12864_pkg.sv - shared types, command constants and timing helpers for the LCD12864 text controller
package lcd12864_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT,
    ST_IDLE,
    ST_CONV,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } lcd_state_t;

  localparam logic [7:0] CMD_FUNC_SET = 8'h30;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;

  // Power-up command sequence; index 3 is the clear that needs the long settle.
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1: return CMD_FUNC_SET;
      3'd2:       return CMD_DISP_ON;
      3'd3:       return CMD_CLEAR;
      default:    return CMD_ENTRY;
    endcase
  endfunction

  // DDRAM set-address command for each of the four display lines.
  function automatic logic [7:0] line_addr(input logic [1:0] line);
    case (line)
      2'd0:    return 8'h80;
      2'd1:    return 8'h90;
      2'd2:    return 8'h88;
      default: return 8'h98;
    endcase
  endfunction

  // Milliseconds to bus ticks, rounded up so waits are never short.
  function automatic logic [31:0] ms_to_ticks(input int ms, input int tick_us);
    return 32'((ms * 1000 + tick_us - 1) / tick_us);
  endfunction

endpackage

// File: rtl/lcd12864_text_ctrl_bin2bcd.sv
// rtl/lcd12864_text_ctrl_bin2bcd.sv - sequential 32-bit binary to 10-digit BCD converter (shift-add-3)
module bin2bcd_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] bin,
  output logic        done,
  output logic [39:0] bcd
);

  logic [31:0] sh;
  logic [4:0]  cnt;
  logic        run;
  logic [39:0] adj;

  // Add 3 to every BCD nibble of 5 or more before the next shift
  always_comb begin
    adj = bcd;
    for (int i = 0; i < 10; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // One shift per clock for 32 clocks, done pulses once the last bit is in
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh   <= '0;
      bcd  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sh  <= bin;
        bcd <= '0;
        cnt <= '0;
        run <= 1'b1;
      end else if (run) begin
        {bcd, sh} <= {adj, sh} << 1;
        cnt       <= cnt + 5'd1;
        if (cnt == 5'd31) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/lcd12864_text_ctrl.sv
// rtl/lcd12864_text_ctrl.sv - ST7920 8-bit parallel 4x16 text painter with decimal field overlay
module lcd12864_text_ctrl
  import lcd12864_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_US    = 80,
  parameter int INIT_MS    = 40,
  parameter int CLR_MS     = 2,
  parameter int DIGITS     = 6,
  parameter int LZ_BLANK   = 1,
  parameter int REFRESH_MS = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [511:0] text_in,
  input  logic [127:0] val_in,
  input  logic [3:0]   val_en,
  input  logic         refresh_req,
  output logic         busy,
  output logic         frame_done,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_psb,
  output logic         lcd_en,
  output logic [7:0]   lcd_db
);

  localparam int          TICK_CYC   = CLK_HZ / 1_000_000 * TICK_US;
  localparam logic [31:0] TICK_LAST  = 32'(TICK_CYC - 1);
  localparam logic [31:0] INIT_TICKS = ms_to_ticks(INIT_MS, TICK_US);
  localparam logic [31:0] CLR_TICKS  = ms_to_ticks(CLR_MS, TICK_US);
  localparam logic [31:0] REF_TICKS  = ms_to_ticks(REFRESH_MS, TICK_US);
  localparam bit          AUTO       = (REFRESH_MS > 0);

  lcd_state_t   state, state_nx;
  logic [31:0]  tick_cnt, wait_cnt, ref_cnt;
  logic         tick, bus_active, byte_done, conv_adv, start_frame;
  logic [1:0]   phase, line;
  logic [2:0]   init_idx, dsel;
  logic [3:0]   col, en_q, ovf_q;
  logic         conv_run, bcd_start, bcd_done, pending;
  logic [39:0]  bcd_out;
  logic [511:0] text_q;
  logic [31:0]  val_q [4];
  logic [31:0]  bcd_q [4];
  logic [31:0]  cur_bcd;
  logic [8:0]   text_msb;
  logic [7:0]   data_byte, cur_db;
  logic         cur_rs;

  assign lcd_rw  = 1'b0;
  assign lcd_psb = 1'b1;

  assign tick        = (tick_cnt == TICK_LAST);
  assign bus_active  = (state == ST_INIT && wait_cnt == '0) || state == ST_ADDR || state == ST_DATA;
  assign byte_done   = bus_active && tick && phase == 2'd2;
  assign conv_adv    = conv_run ? bcd_done : !en_q[line];
  assign start_frame = refresh_req || pending || (AUTO && ref_cnt == '0);

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (bcd_start),
    .bin   (val_q[line]),
    .done  (bcd_done),
    .bcd   (bcd_out)
  );

  // Free-running clock-enable tick that paces every bus phase and wait
  always_ff @(posedge clk) begin
    if (!rst_n) tick_cnt <= '0;
    else        tick_cnt <= tick ? '0 : tick_cnt + 32'd1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_PWRUP;
    else        state <= state_nx;
  end

  // Next-state: power-up wait, init commands, then frames of addr + 16 data bytes per line
  always_comb begin
    state_nx = state;
    case (state)
      ST_PWRUP: if (wait_cnt == '0) state_nx = ST_INIT;
      ST_INIT:  if (byte_done && init_idx == 3'd4) state_nx = ST_IDLE;
      ST_IDLE:  if (start_frame) state_nx = ST_CONV;
      ST_CONV:  if (conv_adv && line == 2'd3) state_nx = ST_ADDR;
      ST_ADDR:  if (byte_done) state_nx = ST_DATA;
      ST_DATA:  if (byte_done && col == 4'hF) state_nx = (line == 2'd3) ? ST_DONE : ST_ADDR;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_PWRUP;
    endcase
  end

  // Data byte for (line, col): raw text, or the decimal field digit / blank / overflow star
  always_comb begin
    text_msb  = 9'd511 - {line, col, 3'b000};
    data_byte = text_q[text_msb -: 8];
    cur_bcd   = bcd_q[line];
    dsel      = 3'(DIGITS - 1) - col[2:0];
    if (en_q[line] && col >= 4'd8 && col <= 4'(7 + DIGITS)) begin
      if (ovf_q[line])
        data_byte = 8'h2A;
      else if (LZ_BLANK != 0 && dsel != 3'd0 && (cur_bcd >> {dsel, 2'b00}) == 32'd0)
        data_byte = 8'h20;
      else
        data_byte = 8'h30 + {4'h0, cur_bcd[{dsel, 2'b00} +: 4]};
    end
  end

  // Byte presented on the bus for the current state
  always_comb begin
    cur_rs = 1'b0;
    cur_db = init_cmd(init_idx);
    if (state == ST_ADDR) begin
      cur_db = line_addr(line);
    end else if (state == ST_DATA) begin
      cur_rs = 1'b1;
      cur_db = data_byte;
    end
  end

  // Bus engine, wait counters, frame snapshot, conversion sequencing and status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase      <= 2'd0;
      lcd_en     <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_db     <= 8'h00;
      wait_cnt   <= INIT_TICKS;
      ref_cnt    <= REF_TICKS;
      init_idx   <= 3'd0;
      line       <= 2'd0;
      col        <= 4'd0;
      conv_run   <= 1'b0;
      bcd_start  <= 1'b0;
      pending    <= 1'b0;
      en_q       <= 4'd0;
      ovf_q      <= 4'd0;
      busy       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      bcd_start  <= 1'b0;
      busy       <= (state_nx != ST_IDLE);
      frame_done <= (state == ST_DONE);

      if (tick && wait_cnt != '0) wait_cnt <= wait_cnt - 32'd1;
      if (state == ST_IDLE && tick && ref_cnt != '0) ref_cnt <= ref_cnt - 32'd1;

      if (bus_active && tick) begin
        case (phase)
          2'd0: begin
            lcd_rs <= cur_rs;
            lcd_db <= cur_db;
            phase  <= 2'd1;
          end
          2'd1: begin
            lcd_en <= 1'b1;
            phase  <= 2'd2;
          end
          default: begin
            lcd_en <= 1'b0;
            phase  <= 2'd0;
          end
        endcase
      end

      if (state == ST_INIT && byte_done) begin
        init_idx <= init_idx + 3'd1;
        if (init_idx == 3'd3) wait_cnt <= CLR_TICKS;
        if (init_idx == 3'd4) ref_cnt <= REF_TICKS;
      end

      if (state != ST_IDLE && refresh_req) pending <= 1'b1;

      if (state == ST_IDLE && start_frame) begin
        pending  <= 1'b0;
        text_q   <= text_in;
        en_q     <= val_en;
        line     <= 2'd0;
        col      <= 4'd0;
        conv_run <= 1'b0;
        for (int i = 0; i < 4; i++) val_q[i] <= val_in[32*i +: 32];
      end

      if (state == ST_CONV) begin
        if (conv_run) begin
          if (bcd_done) begin
            bcd_q[line] <= bcd_out[31:0];
            ovf_q[line] <= (bcd_out >> (4 * DIGITS)) != 40'd0;
            conv_run    <= 1'b0;
            line        <= line + 2'd1;
          end
        end else if (en_q[line]) begin
          conv_run  <= 1'b1;
          bcd_start <= 1'b1;
        end else begin
          line <= line + 2'd1;
        end
      end

      if (state == ST_DATA && byte_done) begin
        if (col == 4'hF) begin
          col  <= 4'd0;
          line <= line + 2'd1;
        end else begin
          col <= col + 4'd1;
        end
      end

      if (state == ST_DONE) ref_cnt <= REF_TICKS;
    end
  end

endmodule
